// File: rtl/adder_pipe_nb.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit carry slice per register stage.
// Valid/ready stream interface; the whole pipe stalls when the output is blocked.
module adder_pipe_nb #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;
    localparam int LAST   = STAGES - 1;

    logic adv;

    logic [STAGES-1:0]            v_q, v_d, c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;

    logic [STAGES-1:0]            src_v, src_c;
    logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;

    logic [CHUNK:0]               part;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k consumes the registers of stage k-1; stage 0 consumes the ports.
    if (STAGES == 1) begin : g_one
        assign src_v = in_valid;
        assign src_c = c_in;
        assign src_a = a;
        assign src_b = b;
        assign src_s = {WIDTH{1'b0}};
    end else begin : g_many
        assign src_v = {v_q[STAGES-2:0], in_valid};
        assign src_c = {c_q[STAGES-2:0], c_in};
        assign src_a = {a_q[STAGES-2:0], a};
        assign src_b = {b_q[STAGES-2:0], b};
        assign src_s = {s_q[STAGES-2:0], {WIDTH{1'b0}}};
    end

    // Each stage adds its slice and forwards operands, partial sum and carry.
    always_comb begin
        v_d  = src_v;
        a_d  = src_a;
        b_d  = src_b;
        s_d  = src_s;
        c_d  = '0;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c[k]};
            s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            c_d[k] = part[CHUNK];
        end
    end

    // All stages advance together, or all hold while the output is blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign c_out     = c_q[LAST];
    assign ovf       = out_valid
                     && (a_q[LAST][MSB] == b_q[LAST][MSB])
                     && (s_q[LAST][MSB] != a_q[LAST][MSB]);
    assign zero      = out_valid && (s_q[LAST] == {WIDTH{1'b0}});

endmodule
